// File: rtl/piso_serial_tx.sv
// Parallel-in, serial-out transmitter: valid/ready word capture, one bit per clock
// on registered sd/sd_valid/last, optional trailing even-parity bit, gap-free back-to-back frames.
module piso_serial_tx #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1,
  parameter int unsigned PARITY_EN = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             sd,
  output logic             sd_valid,
  output logic             last
);

  localparam int unsigned N  = WIDTH + PARITY_EN;
  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
  localparam logic [CW-1:0] PAR_IDX  = CW'(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             par;

  logic             at_last;
  logic             ready_int;
  logic             accept;
  logic [CW-1:0]    cnt_next;

  // Bit selection and shift direction follow the configured transmit order.
  function automatic logic head(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  // Ready while idle or while the final bit is on the line, so frames can abut.
  assign at_last   = (state == SHIFT) && (cnt == LAST_IDX);
  assign ready_int = (state == IDLE) || at_last;
  assign in_ready  = rst & ready_int;
  assign accept    = in_valid & ready_int;
  assign cnt_next  = cnt + CW'(1);

  // shreg holds the bits still to be sent, so its head is always the next data bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      sd       <= 1'b0;
      sd_valid <= 1'b0;
      last     <= 1'b0;
    end else if (accept) begin
      state    <= SHIFT;
      cnt      <= '0;
      shreg    <= advance(in_data);
      par      <= ^in_data;
      sd       <= head(in_data);
      sd_valid <= 1'b1;
      last     <= 1'b0;
    end else if (state == SHIFT) begin
      if (at_last) begin
        state    <= IDLE;
        cnt      <= '0;
        sd       <= 1'b0;
        sd_valid <= 1'b0;
        last     <= 1'b0;
      end else begin
        cnt      <= cnt_next;
        shreg    <= advance(shreg);
        sd       <= ((PARITY_EN != 0) && (cnt_next == PAR_IDX)) ? par : head(shreg);
        sd_valid <= 1'b1;
        last     <= (cnt_next == LAST_IDX);
      end
    end
  end

endmodule

// File: tb/tb_piso_serial_tx.sv
// Scoreboard bench for piso_serial_tx: a default instance (MSB first, no parity)
// and an LSB-first instance with parity, sharing clock and reset.
module tb_piso_serial_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iv0 = 1'b0, iv1 = 1'b0;
  logic [7:0] id0 = 8'h00, id1 = 8'h00;
  logic       rdy0, sd0, sv0, last0;
  logic       rdy1, sd1, sv1, last1;

  int checks = 0;
  int errors = 0;

  logic       exp_q[$];
  logic [7:0] word_q[$];

  always #5 clk = ~clk;

  piso_serial_tx u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_data(id0),
    .in_ready(rdy0), .sd(sd0), .sd_valid(sv0), .last(last0)
  );

  piso_serial_tx #(.WIDTH(8), .MSB_FIRST(0), .PARITY_EN(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_data(id1),
    .in_ready(rdy1), .sd(sd1), .sd_valid(sv1), .last(last1)
  );

  // Expected serial bit sequence for one word.
  function automatic void push_frame(input logic [7:0] w, input bit msb, input bit par_en);
    for (int i = 0; i < 8; i++) exp_q.push_back(msb ? w[7-i] : w[i]);
    if (par_en) exp_q.push_back(^w);
  endfunction

  task automatic test_reset;
    #1 rst = 1'b0;
    iv0 = 1'b1; iv1 = 1'b1; id0 = 8'h5A; id1 = 8'hC3;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({sd0, sv0, last0, rdy0, sd1, sv1, last1, rdy1} !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold got %b want 00000000",
                 {sd0, sv0, last0, rdy0, sd1, sv1, last1, rdy1});
      end
    end
    iv0 = 1'b0; iv1 = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({rdy0, sv0, rdy1, sv1} !== 4'b1010) begin
      errors++;
      $display("FAIL reset_release got %b want 1010", {rdy0, sv0, rdy1, sv1});
    end
  endtask

  task automatic test_single_frame;
    logic e, l;
    exp_q.delete();
    push_frame(8'hA5, 1'b1, 1'b0);
    @(negedge clk); iv0 = 1'b1; id0 = 8'hA5;
    @(posedge clk); #1 iv0 = 1'b0; id0 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      l = (i == 7);
      checks++;
      if ({sd0, sv0, last0, rdy0} !== {e, 1'b1, l, l}) begin
        errors++;
        $display("FAIL single_bit%0d got %b want %b", i, {sd0, sv0, last0, rdy0}, {e, 1'b1, l, l});
      end
    end
    @(negedge clk);
    checks++;
    if ({sd0, sv0, last0, rdy0} !== 4'b0001) begin
      errors++;
      $display("FAIL single_idle got %b want 0001", {sd0, sv0, last0, rdy0});
    end
  endtask

  task automatic test_back_to_back;
    logic e, l;
    int hs = 0;
    exp_q.delete();
    push_frame(8'hA5, 1'b1, 1'b0);
    push_frame(8'h3C, 1'b1, 1'b0);
    @(negedge clk); iv0 = 1'b1; id0 = 8'hA5;
    if (rdy0) hs++;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      l = (i == 7) || (i == 15);
      checks++;
      if ({sd0, sv0, last0} !== {e, 1'b1, l}) begin
        errors++;
        $display("FAIL b2b_bit%0d got %b want %b", i, {sd0, sv0, last0}, {e, 1'b1, l});
      end
      if (iv0 && rdy0) hs++;
      if (i == 0) id0 = 8'h3C;
      if (i == 8) iv0 = 1'b0;
    end
    checks++;
    if (hs != 2) begin
      errors++;
      $display("FAIL b2b_handshakes got %0d want 2", hs);
    end
    @(negedge clk);
    checks++;
    if ({sv0, last0} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_idle got %b want 00", {sv0, last0});
    end
  endtask

  task automatic test_parity_order;
    logic [7:0] pw[2];
    logic e, l;
    pw[0] = 8'h07;
    pw[1] = 8'h03;
    for (int k = 0; k < 2; k++) begin
      exp_q.delete();
      push_frame(pw[k], 1'b0, 1'b1);
      @(negedge clk); iv1 = 1'b1; id1 = pw[k];
      @(posedge clk); #1 iv1 = 1'b0;
      for (int i = 0; i < 9; i++) begin
        @(negedge clk);
        e = exp_q.pop_front();
        l = (i == 8);
        checks++;
        if ({sd1, sv1, last1} !== {e, 1'b1, l}) begin
          errors++;
          $display("FAIL parity_w%0h_bit%0d got %b want %b", pw[k], i, {sd1, sv1, last1}, {e, 1'b1, l});
        end
      end
      @(negedge clk);
      checks++;
      if ({sd1, sv1, last1} !== 3'b000) begin
        errors++;
        $display("FAIL parity_idle got %b want 000", {sd1, sv1, last1});
      end
    end
  endtask

  task automatic test_reset_mid;
    logic e, l;
    exp_q.delete();
    push_frame(8'hFF, 1'b1, 1'b0);
    @(negedge clk); iv0 = 1'b1; id0 = 8'hFF;
    @(posedge clk); #1 iv0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({sd0, sv0, last0} !== {e, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL midrst_bit%0d got %b want %b", i, {sd0, sv0, last0}, {e, 2'b10});
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({sd0, sv0, last0, rdy0} !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_abort got %b want 0000", {sd0, sv0, last0, rdy0});
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({sd0, sv0, last0, rdy0} !== 4'b0000) begin
        errors++;
        $display("FAIL midrst_hold got %b want 0000", {sd0, sv0, last0, rdy0});
      end
    end
    @(posedge clk); #1 rst = 1'b1;
    exp_q.delete();
    push_frame(8'h81, 1'b1, 1'b0);
    @(negedge clk); iv0 = 1'b1; id0 = 8'h81;
    @(posedge clk); #1 iv0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      l = (i == 7);
      checks++;
      if ({sd0, sv0, last0} !== {e, 1'b1, l}) begin
        errors++;
        $display("FAIL postrst_bit%0d got %b want %b", i, {sd0, sv0, last0}, {e, 1'b1, l});
      end
    end
  endtask

  task automatic test_stall;
    word_q.delete();
    fork
      begin : drv
        int sent = 0;
        int dcyc = 0;
        logic [7:0] w = 8'($urandom);
        while (sent < 50 && dcyc < 5000) begin
          @(negedge clk);
          dcyc++;
          iv0 = 1'($urandom_range(0, 1));
          id0 = iv0 ? w : 8'($urandom);
          if (iv0 && rdy0) begin
            word_q.push_back(w);
            sent++;
            w = 8'($urandom);
          end
        end
        @(negedge clk); iv0 = 1'b0;
      end
      begin : mon
        int got = 0;
        int cyc = 0;
        int nb = 0;
        bit inf = 1'b0;
        logic [7:0] acc = 8'h00;
        logic [7:0] ew;
        while (got < 50 && cyc < 5000) begin
          @(negedge clk);
          cyc++;
          if (inf) begin
            checks++;
            if (sv0 !== 1'b1) begin
              errors++;
              $display("FAIL stall_gap frame%0d got sd_valid=%b want 1", got, sv0);
            end
          end
          if (sv0 === 1'b1) begin
            acc = {acc[6:0], sd0};
            nb++;
            if (last0 === 1'b1) begin
              checks++;
              if (word_q.size() == 0) begin
                errors++;
                $display("FAIL stall_extra frame%0d got %h want none", got, acc);
              end else begin
                ew = word_q.pop_front();
                if (acc !== ew || nb != 8) begin
                  errors++;
                  $display("FAIL stall_word frame%0d got %h/%0d bits want %h/8 bits", got, acc, nb, ew);
                end
              end
              got++;
              nb = 0;
              inf = 1'b0;
            end else begin
              inf = 1'b1;
            end
          end
        end
        checks++;
        if (got != 50) begin
          errors++;
          $display("FAIL stall_count got %0d frames want 50", got);
        end
      end
    join
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_parity_order();
    test_reset_mid();
    test_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
